// File: rtl/soc_pkg.sv
// soc_pkg -- shared constants for the DE10-Nano video-controller board top.
//   HALF_PERIOD_DEF : default heartbeat half period in clock cycles (1 Hz at 50 MHz)
//   DEBOUNCE_DEF    : default number of stable samples needed to accept a KEY[1] change
//   LED_*           : bit positions of the user LED functions
//   cnt_width()     : width of a counter that must hold 0..n-1
package soc_pkg;

    localparam int unsigned HALF_PERIOD_DEF = 25_000_000;
    localparam int unsigned DEBOUNCE_DEF    = 500_000;

    localparam int unsigned LED_HEART   = 0;
    localparam int unsigned LED_RST     = 1;
    localparam int unsigned LED_MODE    = 2;
    localparam int unsigned LED_KEY     = 3;
    localparam int unsigned LED_NIB_LSB = 4;

    // A counter for 0..n-1 needs clog2(n) bits; never return a zero width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hws_if.sv
// hws_if -- hardware-support interface towards the SDRAM / HDMI side of the board.
//   master modport (the FPGA fabric top): drives requests and pixel data,
//   receives acknowledge and interrupt.
//   slave modport: the opposite direction.
interface hws_if;

    logic        sdram_req;
    logic        sdram_we;
    logic [15:0] sdram_addr;
    logic        hdmi_de;
    logic [23:0] hdmi_rgb;
    logic        sdram_ack;
    logic        hdmi_int;

    modport master (
        output sdram_req, sdram_we, sdram_addr, hdmi_de, hdmi_rgb,
        input  sdram_ack, hdmi_int
    );

    modport slave (
        input  sdram_req, sdram_we, sdram_addr, hdmi_de, hdmi_rgb,
        output sdram_ack, hdmi_int
    );

endinterface

// File: rtl/reset_sync.sv
// reset_sync -- reset synchronizer: asynchronous assertion, synchronous release.
//   clk_i  : destination clock
//   rst_ni : raw asynchronous active-low reset (any pulse width)
//   rst_no : synchronized active-low reset; rises on the 2nd rising edge of
//            clk_i after rst_ni returns high, falls immediately with rst_ni
module reset_sync (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_no = sync_q;

endmodule

// File: rtl/soc_top.sv
// soc_top -- board-level top of the SoC-FPGA video-controller project.
//   FPGA_CLK1_50 : 50 MHz system clock, all logic on its rising edge
//   KEY[1:0]     : push-buttons, active-low; KEY[0] = async reset, KEY[1] = mode button
//   SW[3:0]      : slide switches
//   LED[7:0]     : user LEDs (1 = lit)
//                  [0] heartbeat, [1] internal reset released, [2] mode,
//                  [3] debounced KEY[1] pressed, [7:4] SW (mode 0) or nibble counter (mode 1)
//   hws_ifm      : hardware-support interface; every output held idle (0), inputs ignored
module soc_top
    import soc_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int unsigned DEBOUNCE    = DEBOUNCE_DEF
) (
    input  logic       FPGA_CLK1_50,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [7:0] LED,
    hws_if.master      hws_ifm
);

    localparam int unsigned HB_W = cnt_width(HALF_PERIOD);
    localparam int unsigned DB_W = cnt_width(DEBOUNCE);

    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HALF_PERIOD - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic clk;
    logic rst_n;

    assign clk = FPGA_CLK1_50;

    // ------------------------------------------------------------------
    // Reset: async assert from KEY[0], release aligned to clk
    // ------------------------------------------------------------------
    reset_sync u_reset_sync (
        .clk_i  (clk),
        .rst_ni (KEY[0]),
        .rst_no (rst_n)
    );

    // ------------------------------------------------------------------
    // Input synchronizers. KEY[1] is inverted first so that every register
    // in the key path holds "pressed" polarity and resets to "not pressed".
    // ------------------------------------------------------------------
    logic       key_meta_q;
    logic       key_sync_q;
    logic [3:0] sw_meta_q;
    logic [3:0] sw_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b0;
            key_sync_q <= 1'b0;
            sw_meta_q  <= 4'h0;
            sw_sync_q  <= 4'h0;
        end else begin
            key_meta_q <= ~KEY[1];
            key_sync_q <= key_meta_q;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // KEY[1] debounce: the debounced level follows the synchronized level
    // only after DEBOUNCE consecutive samples that disagree with it. Any
    // sample that agrees restarts the count, so short bounces are lost.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_db_q, key_db_d;
    logic            mode_q,   mode_d;
    logic            press;

    always_comb begin
        db_cnt_d = db_cnt_q;
        key_db_d = key_db_q;
        if (key_sync_q == key_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            key_db_d = key_sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // A press is the debounced level going from released to pressed;
    // release edges leave the mode alone.
    assign press  = key_db_d & ~key_db_q;
    assign mode_d = mode_q ^ press;

    // ------------------------------------------------------------------
    // Heartbeat and nibble counter. Independent of the mode logic, so a
    // wrap and a press landing in the same cycle both take effect.
    // ------------------------------------------------------------------
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            heart_q,  heart_d;
    logic [3:0]      nib_q,    nib_d;
    logic            hb_wrap;

    assign hb_wrap  = (hb_cnt_q == HB_LAST);
    assign hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
    assign heart_d  = heart_q ^ hb_wrap;
    assign nib_d    = nib_q + {3'b000, hb_wrap};  // 4-bit add wraps 15 -> 0

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            key_db_q <= 1'b0;
            mode_q   <= 1'b0;
            hb_cnt_q <= '0;
            heart_q  <= 1'b0;
            nib_q    <= 4'h0;
        end else begin
            db_cnt_q <= db_cnt_d;
            key_db_q <= key_db_d;
            mode_q   <= mode_d;
            hb_cnt_q <= hb_cnt_d;
            heart_q  <= heart_d;
            nib_q    <= nib_d;
        end
    end

    // ------------------------------------------------------------------
    // LED map. All sources are registers cleared by rst_n, so the whole
    // LED bus reads 0 as soon as KEY[0] goes low.
    // ------------------------------------------------------------------
    assign LED[LED_HEART]           = heart_q;
    assign LED[LED_RST]             = rst_n;
    assign LED[LED_MODE]            = mode_q;
    assign LED[LED_KEY]             = key_db_q;
    assign LED[LED_NIB_LSB +: 4]    = mode_q ? nib_q : sw_sync_q;

    // ------------------------------------------------------------------
    // Hardware-support interface parked idle.
    // ------------------------------------------------------------------
    assign hws_ifm.sdram_req  = 1'b0;
    assign hws_ifm.sdram_we   = 1'b0;
    assign hws_ifm.sdram_addr = 16'h0000;
    assign hws_ifm.hdmi_de    = 1'b0;
    assign hws_ifm.hdmi_rgb   = 24'h000000;

    logic unused_hws_inputs;
    assign unused_hws_inputs = hws_ifm.sdram_ack ^ hws_ifm.hdmi_int;

endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top -- self-checking bench for soc_top with a behavioural model.
// The model describes the board in terms of elapsed time: cycles since the
// reset button was released, number of clean presses, last switch value.
module tb_soc_top;

    localparam int HP = 1000;
    localparam int DB = 50;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       key0 = 1'b1;
    logic       key1 = 1'b1;
    logic [3:0] sw = 4'h0;
    logic [1:0] key;
    logic [7:0] led;

    always #10 clk = ~clk;
    assign key = {key1, key0};

    hws_if hws ();

    soc_top #(
        .HALF_PERIOD (HP),
        .DEBOUNCE    (DB)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .KEY          (key),
        .SW           (sw),
        .LED          (led),
        .hws_ifm      (hws)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and the single checking task
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: time since reset release.
    //   rel_m counts rising edges after KEY[0] returns high (saturates at 2,
    //   when the internal reset is released); hb_m counts edges after that.
    // ------------------------------------------------------------------
    int rel_m = 0;
    int hb_m  = 0;
    logic rst_exp;
    logic heart_exp;
    logic [3:0] nib_exp;

    always @(posedge clk or negedge key0) begin
        if (!key0) begin
            rel_m <= 0;
            hb_m  <= 0;
        end else if (rel_m < 2) begin
            rel_m <= rel_m + 1;
        end else begin
            hb_m <= hb_m + 1;
        end
    end

    assign rst_exp   = (rel_m >= 2);
    assign heart_exp = ((hb_m / HP) % 2) == 1;
    assign nib_exp   = 4'((hb_m / HP) % 16);

    // Continuous checks, sampled on the falling edge.
    logic chk_hb  = 1'b0;
    logic chk_nib = 1'b0;

    always @(negedge clk) begin
        if (chk_hb)
            check_eq("led_hb_rst", {30'd0, led[1:0]}, {30'd0, rst_exp, heart_exp});
        if (chk_nib)
            check_eq("led_nibble", {28'd0, led[7:4]}, {28'd0, nib_exp});
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw_and_check(input logic [3:0] v);
        @(negedge clk);
        sw = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("sw_follow", {28'd0, led[7:4]}, {28'd0, v});
    endtask

    task automatic clean_press(input logic exp_mode);
        @(negedge clk);
        key1 = 1'b0;
        cycles(DB + 30);
        check_eq("key_held", {31'd0, led[3]}, 32'd1);
        check_eq("mode_press", {31'd0, led[2]}, {31'd0, exp_mode});
        key1 = 1'b1;
        cycles(DB + 30);
        check_eq("key_released", {31'd0, led[3]}, 32'd0);
        check_eq("mode_release", {31'd0, led[2]}, {31'd0, exp_mode});
    endtask

    task automatic check_hws_idle();
        hws.sdram_ack = 1'($urandom_range(0, 1));
        hws.hdmi_int  = 1'($urandom_range(0, 1));
        #1;
        check_eq("hws_idle", {27'd0, hws.sdram_req, hws.sdram_we, hws.hdmi_de,
                              |hws.sdram_addr, |hws.hdmi_rgb}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int   toggles;
    logic prev;
    logic found;
    logic mode_m;

    initial begin
        hws.sdram_ack = 1'b0;
        hws.hdmi_int  = 1'b0;
        mode_m = 1'b0;
        cycles(3);

        // Short reset pulse (18 ns) straddling one rising edge.
        @(negedge clk);
        #3 key0 = 1'b0;
        #2 check_eq("rst_leds", {24'd0, led}, 32'd0);
        #16 key0 = 1'b1;
        chk_hb = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_release", {31'd0, led[1]}, 32'd1);
        check_hws_idle();

        // Heartbeat: count toggles over 20 half periods.
        toggles = 0;
        prev = led[0];
        for (int i = 0; i < 20 * HP + 8; i++) begin
            @(negedge clk);
            if (led[0] != prev) toggles++;
            prev = led[0];
        end
        check_eq("hb_toggles", toggles, 20);

        // Switches in mode 0: fixed patterns then random ones.
        set_sw_and_check(4'hA);
        set_sw_and_check(4'h5);
        for (int i = 0; i < 4; i++)
            set_sw_and_check(4'($urandom_range(0, 15)));

        // Clean press -> mode 1, LED[7:4] follows the nibble counter.
        mode_m = ~mode_m;
        clean_press(mode_m);
        chk_nib = 1'b1;
        cycles(17 * HP);   // covers a full F -> 0 wrap
        check_hws_idle();

        // Bounces shorter than the debounce window: mode stays put.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key1 = ~key1;
            cycles($urandom_range(1, 20));
        end
        @(negedge clk);
        key1 = 1'b1;
        cycles(DB + 30);
        check_eq("bounce_mode", {31'd0, led[2]}, {31'd0, mode_m});
        check_eq("bounce_key", {31'd0, led[3]}, 32'd0);

        // Second clean press returns to switch display.
        chk_nib = 1'b0;
        mode_m = ~mode_m;
        clean_press(mode_m);
        check_eq("mode0_sw", {28'd0, led[7:4]}, {28'd0, sw});

        // Third press, then reset in the middle of nibble 7.
        mode_m = ~mode_m;
        clean_press(mode_m);
        chk_nib = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 * HP && !found; i++) begin
            @(negedge clk);
            if (nib_exp == 4'd7 && (hb_m % HP) == HP / 2) found = 1'b1;
        end
        check_eq("nib7_reached", {31'd0, found}, 32'd1);
        check_eq("nib7_pre", {28'd0, led[7:4]}, 32'd7);
        check_eq("mode_pre", {31'd0, led[2]}, 32'd1);
        chk_nib = 1'b0;
        mode_m = 1'b0;
        #3 key0 = 1'b0;
        #2;
        check_eq("async_led0", {31'd0, led[0]}, 32'd0);
        check_eq("async_mode", {31'd0, led[2]}, 32'd0);
        check_eq("async_nib", {28'd0, led[7:4]}, 32'd0);
        check_eq("async_all", {24'd0, led}, 32'd0);
        cycles(3);
        key0 = 1'b1;
        cycles(10);
        check_eq("post_rst_mode", {31'd0, led[2]}, {31'd0, mode_m});
        check_eq("post_rst_sw", {28'd0, led[7:4]}, {28'd0, sw});
        check_hws_idle();

        chk_hb = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
